// File: rtl/kdtree_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : kdtree_load_ctrl
//  Description : Drains the kd-tree load stream from a first-word-fall-through
//                FIFO (internal nodes, then leaf patches, then query patches),
//                assembles each multi-word record and issues one registered
//                write strobe with address per record to the node, leaf and
//                query memories. Signals completion to the main FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module kdtree_load_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int LEAF_SIZE  = 8,
    parameter int NUM_LEAVES = 64,
    parameter int NUM_QUERYS = 494,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load_kdtree,
    input  logic [DATA_WIDTH-1:0]              fifo_rdata,
    input  logic                               fifo_rempty_n,
    output logic                               fifo_deq,
    output logic                               node_wen,
    output logic [$clog2(NUM_LEAVES)-1:0]      node_addr,
    output logic [IDX_WIDTH+DATA_WIDTH-1:0]    node_wdata,
    output logic                               leaf_wen,
    output logic [$clog2(NUM_LEAVES)-1:0]      leaf_addr,
    output logic [$clog2(LEAF_SIZE)-1:0]       leaf_patch_sel,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0]   leaf_wdata,
    output logic [DATA_WIDTH-1:0]              leaf_pidx,
    output logic                               query_wen,
    output logic [$clog2(NUM_QUERYS)-1:0]      query_addr,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0]   query_wdata,
    output logic                               busy,
    output logic                               load_done,
    output logic                               kdtree_valid
);

    localparam int c_leaf_aw  = $clog2(NUM_LEAVES);
    localparam int c_sel_w    = $clog2(LEAF_SIZE);
    localparam int c_query_aw = $clog2(NUM_QUERYS);
    localparam int c_wc_w     = $clog2(PATCH_SIZE + 1);
    localparam int c_patch_w  = PATCH_SIZE * DATA_WIDTH;

    localparam logic [c_leaf_aw-1:0]  c_node_last  = c_leaf_aw'(NUM_LEAVES - 2);
    localparam logic [c_leaf_aw-1:0]  c_leaf_last  = c_leaf_aw'(NUM_LEAVES - 1);
    localparam logic [c_leaf_aw-1:0]  c_leaf_one   = c_leaf_aw'(1);
    localparam logic [c_sel_w-1:0]    c_sel_last   = c_sel_w'(LEAF_SIZE - 1);
    localparam logic [c_sel_w-1:0]    c_sel_one    = c_sel_w'(1);
    localparam logic [c_query_aw-1:0] c_query_last = c_query_aw'(NUM_QUERYS - 1);
    localparam logic [c_query_aw-1:0] c_query_one  = c_query_aw'(1);
    localparam logic [c_wc_w-1:0]     c_wc_one     = c_wc_w'(1);
    localparam logic [c_wc_w-1:0]     c_wc_pdata   = c_wc_w'(PATCH_SIZE - 1);
    localparam logic [c_wc_w-1:0]     c_wc_pidx    = c_wc_w'(PATCH_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NODE  = 2'd1,
        S_LEAF  = 2'd2,
        S_QUERY = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [c_wc_w-1:0]     r_word_cnt;     // word position inside current record
    logic [c_leaf_aw-1:0]  r_node_cnt;
    logic [c_leaf_aw-1:0]  r_leaf_cnt;
    logic [c_sel_w-1:0]    r_sel_cnt;
    logic [c_query_aw-1:0] r_query_cnt;
    logic [IDX_WIDTH-1:0]  r_split;
    logic [c_patch_w-1:0]  r_patch;        // patch words assembled so far

    logic                  w_deq;
    logic                  w_node_rec_end;
    logic                  w_leaf_rec_end;
    logic                  w_query_rec_end;
    logic                  w_node_phase_end;
    logic                  w_leaf_phase_end;
    logic                  w_query_phase_end;
    logic [c_patch_w-1:0]  w_patch_merged;

    assign w_deq    = (r_state != S_IDLE) & fifo_rempty_n;
    assign fifo_deq = w_deq;
    assign busy     = (r_state != S_IDLE);

    assign w_node_rec_end    = w_deq && (r_state == S_NODE)  && (r_word_cnt == c_wc_one);
    assign w_leaf_rec_end    = w_deq && (r_state == S_LEAF)  && (r_word_cnt == c_wc_pidx);
    assign w_query_rec_end   = w_deq && (r_state == S_QUERY) && (r_word_cnt == c_wc_pdata);
    assign w_node_phase_end  = w_node_rec_end && (r_node_cnt == c_node_last);
    assign w_leaf_phase_end  = w_leaf_rec_end && (r_leaf_cnt == c_leaf_last)
                               && (r_sel_cnt == c_sel_last);
    assign w_query_phase_end = w_query_rec_end && (r_query_cnt == c_query_last);

    // Patch buffer with the current FIFO word dropped into its slot; the last
    // query word goes straight to the output register through this path.
    always_comb begin
        w_patch_merged = r_patch;
        for (int i = 0; i < PATCH_SIZE; i++) begin
            if (r_word_cnt == c_wc_w'(i)) begin
                w_patch_merged[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Phase sequencing: each phase ends on the consumption of its last word.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (load_kdtree)       w_state_next = S_NODE;
            S_NODE:  if (w_node_phase_end)  w_state_next = S_LEAF;
            S_LEAF:  if (w_leaf_phase_end)  w_state_next = S_QUERY;
            S_QUERY: if (w_query_phase_end) w_state_next = S_IDLE;
            default:                        w_state_next = S_IDLE;
        endcase
    end

    // Record assembly, counters and registered memory write ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt     <= '0;
            r_node_cnt     <= '0;
            r_leaf_cnt     <= '0;
            r_sel_cnt      <= '0;
            r_query_cnt    <= '0;
            r_split        <= '0;
            r_patch        <= '0;
            node_wen       <= 1'b0;
            node_addr      <= '0;
            node_wdata     <= '0;
            leaf_wen       <= 1'b0;
            leaf_addr      <= '0;
            leaf_patch_sel <= '0;
            leaf_wdata     <= '0;
            leaf_pidx      <= '0;
            query_wen      <= 1'b0;
            query_addr     <= '0;
            query_wdata    <= '0;
            load_done      <= 1'b0;
            kdtree_valid   <= 1'b0;
        end else begin
            node_wen  <= 1'b0;
            leaf_wen  <= 1'b0;
            query_wen <= 1'b0;
            load_done <= 1'b0;

            if ((r_state == S_IDLE) && load_kdtree) begin
                kdtree_valid <= 1'b0;
                r_word_cnt   <= '0;
                r_node_cnt   <= '0;
            end

            if (w_deq) begin
                case (r_state)
                    S_NODE: begin
                        if (r_word_cnt == '0) begin
                            r_split    <= fifo_rdata[IDX_WIDTH-1:0];
                            r_word_cnt <= c_wc_one;
                        end else begin
                            node_wen   <= 1'b1;
                            node_addr  <= r_node_cnt;
                            node_wdata <= {r_split, fifo_rdata};
                            r_word_cnt <= '0;
                            r_node_cnt <= r_node_cnt + c_leaf_one;
                            if (w_node_phase_end) begin
                                r_leaf_cnt <= '0;
                                r_sel_cnt  <= '0;
                            end
                        end
                    end
                    S_LEAF: begin
                        r_patch <= w_patch_merged;
                        if (w_leaf_rec_end) begin
                            leaf_wen       <= 1'b1;
                            leaf_addr      <= r_leaf_cnt;
                            leaf_patch_sel <= r_sel_cnt;
                            leaf_wdata     <= r_patch;
                            leaf_pidx      <= fifo_rdata;
                            r_word_cnt     <= '0;
                            if (r_sel_cnt == c_sel_last) begin
                                r_sel_cnt  <= '0;
                                r_leaf_cnt <= r_leaf_cnt + c_leaf_one;
                            end else begin
                                r_sel_cnt  <= r_sel_cnt + c_sel_one;
                            end
                            if (w_leaf_phase_end) begin
                                r_query_cnt <= '0;
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + c_wc_one;
                        end
                    end
                    S_QUERY: begin
                        r_patch <= w_patch_merged;
                        if (w_query_rec_end) begin
                            query_wen   <= 1'b1;
                            query_addr  <= r_query_cnt;
                            query_wdata <= w_patch_merged;
                            r_word_cnt  <= '0;
                            r_query_cnt <= r_query_cnt + c_query_one;
                            if (w_query_phase_end) begin
                                load_done    <= 1'b1;
                                kdtree_valid <= 1'b1;
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + c_wc_one;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kdtree_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kdtree_load_ctrl
//  Description : Directed self-checking bench for kdtree_load_ctrl. Streams
//                full kd-tree loads through a modelled FWFT FIFO, with an
//                empty gap inside a leaf patch, a stray load pulse mid-load
//                and an asynchronous reset mid-query.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kdtree_load_ctrl;

    localparam int DW = 11;
    localparam int PS = 5;
    localparam int LS = 8;
    localparam int NL = 64;
    localparam int NQ = 494;
    localparam int IW = 3;

    localparam int NODE_WORDS   = 2 * (NL - 1);         // 126
    localparam int LEAF_WORDS   = NL * LS * (PS + 1);   // 3072
    localparam int QUERY_WORDS  = NQ * PS;              // 2470
    localparam int STREAM_LEN   = NODE_WORDS + LEAF_WORDS + QUERY_WORDS;
    localparam int GAP_PATCH    = 20;
    localparam int GAP_BASE     = NODE_WORDS + GAP_PATCH * (PS + 1);
    localparam int GAP_PTR      = GAP_BASE + 3;
    localparam int MID_LOAD_PTR = 1000;
    localparam int RESET_PTR    = 4000;
    localparam int BUDGET       = 8000;

    logic                 clk;
    logic                 rst_n;
    logic                 load_kdtree;
    logic [DW-1:0]        fifo_rdata;
    logic                 fifo_rempty_n;
    logic                 fifo_deq;
    logic                 node_wen;
    logic [5:0]           node_addr;
    logic [IW+DW-1:0]     node_wdata;
    logic                 leaf_wen;
    logic [5:0]           leaf_addr;
    logic [2:0]           leaf_patch_sel;
    logic [PS*DW-1:0]     leaf_wdata;
    logic [DW-1:0]        leaf_pidx;
    logic                 query_wen;
    logic [8:0]           query_addr;
    logic [PS*DW-1:0]     query_wdata;
    logic                 busy;
    logic                 load_done;
    logic                 kdtree_valid;

    kdtree_load_ctrl #(
        .DATA_WIDTH (DW),
        .PATCH_SIZE (PS),
        .LEAF_SIZE  (LS),
        .NUM_LEAVES (NL),
        .NUM_QUERYS (NQ),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_kdtree    (load_kdtree),
        .fifo_rdata     (fifo_rdata),
        .fifo_rempty_n  (fifo_rempty_n),
        .fifo_deq       (fifo_deq),
        .node_wen       (node_wen),
        .node_addr      (node_addr),
        .node_wdata     (node_wdata),
        .leaf_wen       (leaf_wen),
        .leaf_addr      (leaf_addr),
        .leaf_patch_sel (leaf_patch_sel),
        .leaf_wdata     (leaf_wdata),
        .leaf_pidx      (leaf_pidx),
        .query_wen      (query_wen),
        .query_addr     (query_addr),
        .query_wdata    (query_wdata),
        .busy           (busy),
        .load_done      (load_done),
        .kdtree_valid   (kdtree_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stream / FIFO model state
    int ptr;
    bit stall;
    bit prev_stall;
    int gap_left;
    bit gap_en;
    bit mid_load_en;
    bit load_req;
    bit took;

    // observations of one load
    int n_node, n_leaf, n_query, n_done, multi_wen, gap_wen, gap_deq;
    int first_node_addr, last_node_addr, first_leaf_ptr;
    int last_leaf_addr, last_leaf_sel, last_query_addr, gap_leaf_ptr;
    logic [IW+DW-1:0] first_node_wdata;
    logic [PS*DW-1:0] first_query_wdata, gap_leaf_wdata;
    logic [DW-1:0]    gap_leaf_pidx;
    logic             done_with_qwen, busy_at_done;
    bit               aborted;

    function automatic logic [DW-1:0] word(input int i);
        return DW'(i * 514 + 3);
    endfunction

    function automatic logic [PS*DW-1:0] patch_at(input int base);
        logic [PS*DW-1:0] p;
        for (int k = 0; k < PS; k++) p[k*DW +: DW] = word(base + k);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs of the previous edge, drive FIFO head, advance.
    task automatic step();
        @(negedge clk);
        if (prev_stall && leaf_wen) gap_wen++;
        if ((int'(node_wen) + int'(leaf_wen) + int'(query_wen)) > 1) multi_wen++;
        if (node_wen) begin
            n_node++;
            if (n_node == 1) begin
                first_node_addr  = int'(node_addr);
                first_node_wdata = node_wdata;
            end
            last_node_addr = int'(node_addr);
        end
        if (leaf_wen) begin
            n_leaf++;
            if (n_leaf == 1) first_leaf_ptr = ptr;
            if (n_leaf == GAP_PATCH + 1) begin
                gap_leaf_wdata = leaf_wdata;
                gap_leaf_pidx  = leaf_pidx;
                gap_leaf_ptr   = ptr;
            end
            last_leaf_addr = int'(leaf_addr);
            last_leaf_sel  = int'(leaf_patch_sel);
        end
        if (query_wen) begin
            n_query++;
            if (n_query == 1) first_query_wdata = query_wdata;
            last_query_addr = int'(query_addr);
        end
        if (load_done) begin
            n_done++;
            done_with_qwen = query_wen;
            busy_at_done   = busy;
        end

        stall = 1'b0;
        if (gap_en && ptr == GAP_PTR && gap_left > 0) begin
            stall = 1'b1;
            gap_left--;
        end
        load_kdtree   = load_req || (mid_load_en && ptr == MID_LOAD_PTR);
        fifo_rempty_n = (ptr < STREAM_LEN) && !stall;
        fifo_rdata    = word(ptr);
        #1;
        took = fifo_deq;
        if (stall && fifo_deq) gap_deq++;
        prev_stall = stall;
        @(posedge clk);
        if (took) ptr++;
    endtask

    task automatic run_load(input bit gap, input bit midload, input int abort_ptr);
        int cyc;
        ptr = 0; n_node = 0; n_leaf = 0; n_query = 0; n_done = 0;
        multi_wen = 0; gap_wen = 0; gap_deq = 0;
        first_node_addr = -1; last_node_addr = -1; first_leaf_ptr = -1;
        last_leaf_addr = -1; last_leaf_sel = -1; last_query_addr = -1; gap_leaf_ptr = -1;
        first_node_wdata = '0; first_query_wdata = '0; gap_leaf_wdata = '0; gap_leaf_pidx = '0;
        done_with_qwen = 1'b0; busy_at_done = 1'b1;
        gap_en = gap; gap_left = 10; mid_load_en = midload; prev_stall = 1'b0;
        aborted = 1'b0;

        load_req = 1'b1;
        step();
        load_req = 1'b0;
        #1;
        chk("valid_clr_on_load", 64'(kdtree_valid), 64'd0);
        chk("busy_after_load",   64'(busy),         64'd1);

        cyc = 0;
        while (n_done == 0 && cyc < BUDGET) begin
            if (abort_ptr >= 0 && ptr >= abort_ptr) begin
                aborted = 1'b1;
                return;
            end
            step();
            cyc++;
        end
        chk("load_done_seen", 64'(n_done != 0), 64'd1);
        repeat (3) step();
    endtask

    task automatic check_full(input string t);
        logic [IW+DW-1:0] exp_nw;
        exp_nw = {3'd3, 11'd517};
        chk({t, "_first_node_addr"},  64'(first_node_addr),  64'd0);
        chk({t, "_first_node_wdata"}, 64'(first_node_wdata), 64'(exp_nw));
        chk({t, "_last_node_addr"},   64'(last_node_addr),   64'd62);
        chk({t, "_first_leaf_ptr"},   64'(first_leaf_ptr),   64'd132);
        chk({t, "_n_node"},           64'(n_node),           64'd63);
        chk({t, "_n_leaf"},           64'(n_leaf),           64'd512);
        chk({t, "_last_leaf_addr"},   64'(last_leaf_addr),   64'd63);
        chk({t, "_last_leaf_sel"},    64'(last_leaf_sel),    64'd7);
        chk({t, "_n_query"},          64'(n_query),          64'd494);
        chk({t, "_last_query_addr"},  64'(last_query_addr),  64'd493);
        chk({t, "_first_query_data"}, 64'(first_query_wdata),
            64'(patch_at(NODE_WORDS + LEAF_WORDS)));
        chk({t, "_n_done"},           64'(n_done),           64'd1);
        chk({t, "_done_with_qwen"},   64'(done_with_qwen),   64'd1);
        chk({t, "_busy_at_done"},     64'(busy_at_done),     64'd0);
        chk({t, "_kdtree_valid"},     64'(kdtree_valid),     64'd1);
        chk({t, "_multi_wen"},        64'(multi_wen),        64'd0);
        chk({t, "_words_consumed"},   64'(ptr),              64'(STREAM_LEN));
        chk({t, "_gap_leaf_ptr"},     64'(gap_leaf_ptr),     64'(GAP_BASE + PS + 1));
        chk({t, "_gap_leaf_wdata"},   64'(gap_leaf_wdata),   64'(patch_at(GAP_BASE)));
        chk({t, "_gap_leaf_pidx"},    64'(gap_leaf_pidx),    64'(word(GAP_BASE + PS)));
    endtask

    initial begin
        // reset with data present at the FIFO head
        rst_n = 1'b0; load_kdtree = 1'b1; fifo_rempty_n = 1'b1; fifo_rdata = 11'd5;
        load_req = 1'b0; mid_load_en = 1'b0; gap_en = 1'b0; ptr = 0; stall = 1'b0;
        #22;
        chk("rst_fifo_deq",  64'(fifo_deq),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_node",      64'({node_wen, node_addr, node_wdata}), 64'd0);
        chk("rst_leaf",      64'({leaf_wen, leaf_addr, leaf_patch_sel, leaf_pidx}), 64'd0);
        chk("rst_leaf_data", 64'(leaf_wdata), 64'd0);
        chk("rst_query",     64'({query_wen, query_addr}), 64'd0);
        chk("rst_query_data",64'(query_wdata), 64'd0);
        chk("rst_done_valid",64'({load_done, kdtree_valid}), 64'd0);
        load_kdtree = 1'b0; fifo_rempty_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // clean back-to-back load
        run_load(1'b0, 1'b0, -1);
        check_full("clean");

        // empty gap inside leaf patch 20 plus a stray load pulse during LEAF
        run_load(1'b1, 1'b1, -1);
        check_full("gap");
        chk("gap_no_deq",  64'(gap_deq), 64'd0);
        chk("gap_no_wen",  64'(gap_wen), 64'd0);

        // asynchronous reset in the middle of the query phase
        run_load(1'b0, 1'b0, RESET_PTR);
        chk("abort_reached", 64'(aborted), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",      64'(busy),      64'd0);
        chk("abort_fifo_deq",  64'(fifo_deq),  64'd0);
        chk("abort_node_addr", 64'(node_addr), 64'd0);
        chk("abort_valid",     64'(kdtree_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_load(1'b0, 1'b0, -1);
        check_full("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
